// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and default constants for the truth-table sweep sequencer.
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         DEF_N_IN     = 3;
    localparam int         DEF_SETTLE   = 2;
    localparam logic [7:0] DEF_EXPECTED = 8'h31;

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Hold counter: cleared by load, advanced by count, expire flags the last settle cycle.
module truth_table_sequencer_settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a combinational block, compares its output
// against a golden truth table and reports per-vector mismatches.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int                  N_IN     = DEF_N_IN,
    parameter int                  SETTLE   = DEF_SETTLE,
    parameter logic [2**N_IN-1:0]  EXPECTED = DEF_EXPECTED
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                dut_y,
    output logic [N_IN-1:0]     dut_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2**N_IN-1:0]  fail_mask,
    output logic [N_IN:0]       err_count
);

    localparam int              NV       = 2**N_IN;
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NV - 1);

    state_e             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [NV-1:0]      fail_mask_q, fail_mask_d;
    logic [N_IN:0]      err_count_q, err_count_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               timer_load, timer_count, timer_expire;

    truth_table_sequencer_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .count  (timer_count),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        timer_load  = 1'b0;
        timer_count = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    vec_d       = '0;
                    fail_mask_d = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    timer_load  = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    vec_d      = '0;
                    timer_load = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    timer_count = 1'b1;
                    if (timer_expire) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                timer_load = 1'b1;
                if (abort) begin
                    vec_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    if (dut_y != EXPECTED[vec_q]) begin
                        fail_mask_d[vec_q] = 1'b1;
                        err_count_d        = err_count_q + (N_IN+1)'(1);
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + N_IN'(1);
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_DONE: begin
                // err_count already includes the final vector's check here
                done_d  = 1'b1;
                pass_d  = (err_count_q == '0);
                vec_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                vec_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            fail_mask_q <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    assign dut_in    = vec_q;
    assign busy      = (state_q == ST_HOLD) || (state_q == ST_CHECK);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: behavioural block-under-test models drive dut_y, results checked with immediate assertions.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, dut_y;
    logic [2:0] dut_in;
    logic       busy, done, pass;
    logic [7:0] fail_mask;
    logic [3:0] err_count;

    int mode;         // 0 = correct block, 1 = inverted, 2 = stuck at 0
    int n_total = 0;
    int n_pass  = 0;
    int cyc;
    int trace [0:127];

    truth_table_sequencer #(
        .N_IN     (3),
        .SETTLE   (2),
        .EXPECTED (8'h31)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dut_y     (dut_y),
        .dut_in    (dut_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // y = ~b&~c | a&~b with dut_in = {a,b,c}
    always_comb begin
        logic good;
        good = (~dut_in[1] & ~dut_in[0]) | (dut_in[2] & ~dut_in[1]);
        case (mode)
            1:       dut_y = ~good;
            2:       dut_y = 1'b0;
            default: dut_y = good;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen (bounded); cyc = edges after the start edge.
    task automatic run_sweep();
        cyc = 0;
        while (!done && cyc < 100) begin
            step();
            cyc++;
            trace[cyc] = int'(dut_in);
        end
    endtask

    initial begin
        int bad;
        int seen;
        mode  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_mask", fail_mask, 0);
        chk("rst_err", err_count, 0);
        chk("rst_dut_in", dut_in, 0);

        // Correct block, start on first edge after reset release
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("A_busy_start", busy, 1);
        chk("A_dut_in_start", dut_in, 0);
        run_sweep();
        chk("A_done_cycle", cyc, 25);
        chk("A_pass", pass, 1);
        chk("A_err", err_count, 0);
        chk("A_mask", fail_mask, 8'h00);
        chk("A_busy_end", busy, 0);
        step();
        chk("A_done_pulse", done, 0);
        chk("A_pass_hold", pass, 1);

        // Abort during vector 3 CHECK with the inverted block
        mode  = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        chk("D_pre_busy", busy, 1);
        chk("D_pre_vec", dut_in, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("D_busy", busy, 0);
        chk("D_dut_in", dut_in, 0);
        chk("D_mask", fail_mask, 8'h07);
        chk("D_err", err_count, 3);
        chk("D_pass", pass, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (done) seen++;
        end
        chk("D_no_done", seen, 0);

        // start together with abort in IDLE: nothing starts, results held
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("SA_busy", busy, 0);
        chk("SA_mask_hold", fail_mask, 8'h07);

        // Inverted block: every vector mismatches
        start = 1'b1;
        step();
        start = 1'b0;
        run_sweep();
        chk("B_done_cycle", cyc, 25);
        chk("B_pass", pass, 0);
        chk("B_err", err_count, 8);
        chk("B_mask", fail_mask, 8'hFF);

        // Stuck-at-0 block, also check dut_in sequence
        mode  = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        trace[0] = int'(dut_in);
        run_sweep();
        chk("C_done_cycle", cyc, 25);
        chk("C_pass", pass, 0);
        chk("C_err", err_count, 3);
        chk("C_mask", fail_mask, 8'h31);
        bad = 0;
        for (int k = 0; k < 24; k++) begin
            if (trace[k] != k / 3) bad++;
        end
        chk("C_dut_in_seq", bad, 0);

        // Repeated start while busy, then reset mid-sweep
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("E_restart_ignored", dut_in, 1);
        chk("E_err_mid", err_count, 1);
        rst_n = 1'b0;
        step();
        chk("E_rst_busy", busy, 0);
        chk("E_rst_dut_in", dut_in, 0);
        chk("E_rst_mask", fail_mask, 0);
        chk("E_rst_err", err_count, 0);
        chk("E_rst_pass", pass, 0);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("E_busy_restart", busy, 1);
        run_sweep();
        chk("E_done_cycle", cyc, 25);
        chk("E_mask", fail_mask, 8'h31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
